memwb_stage: RTL and testbench

Memory-access and writeback stage of the pipelined processor. It produces the writeback interface that the decode stage consumes: RegWriteEnW, RDW and ResultW. It accepts memory-stage controls and data, and performs loads and stores against an internal word-addressed data memory with configurable access latency. While an access is in flight it asserts StallM so upstream stages hold, then registers the selected result into the W stage.

---
 rtl/memwb_stage.sv | 116 +++++++++++
 tb/tb_memwb_stage.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/memwb_stage.sv
// Memory-access and writeback stage. It holds a word-addressed data memory with a
// fixed access latency, stalls upstream while an access is in flight, and registers the W result.
module memwb_stage #(
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = 8,
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ValidM,
    input  logic        RegWriteEnM,
    input  logic        MemtoRegM,
    input  logic        MemReadEnM,
    input  logic        MemWriteEnM,
    input  logic        JALM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [4:0]  RdM,
    input  logic [31:0] PCPlus4M,
    output logic        StallM,
    output logic        ValidW,
    output logic        RegWriteEnW,
    output logic [4:0]  RDW,
    output logic [31:0] ResultW,
    output logic        ErrW
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [3:0] LAT_M1 = (MEM_LATENCY > 0) ? 4'(MEM_LATENCY - 1) : 4'd0;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [31:0]       mem_q [DEPTH];

    logic              memop;
    logic              bad;
    logic              complete;
    logic              load_sel;
    logic [ADDR_W-1:0] word_idx;
    logic [31:0]       mem_rdata;
    logic [31:0]       result_d;

    assign memop     = ValidM & (MemReadEnM | MemWriteEnM);
    assign word_idx  = ALUResultM[ADDR_W+1:2];
    assign bad       = (ALUResultM[1:0] != 2'b00) | (|ALUResultM[31:ADDR_W+2]);
    assign mem_rdata = bad ? 32'd0 : mem_q[word_idx];
    assign complete  = memop & ~StallM;
    assign load_sel  = MemtoRegM & MemReadEnM & ~MemWriteEnM;
    assign result_d  = JALM ? PCPlus4M : (load_sel ? mem_rdata : ALUResultM);

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        StallM  = 1'b0;
        case (state_q)
            IDLE: begin
                if (memop && (MEM_LATENCY > 0)) begin
                    StallM  = 1'b1;
                    state_d = BUSY;
                    cnt_d   = LAT_M1;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    StallM = 1'b1;
                    cnt_d  = cnt_q - 4'd1;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
        // Reset takes priority, so upstream is never held while the stage is being cleared.
        if (!rst) StallM = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: the memory array has no reset. Only the write is gated, so reset aborts a pending store.
    always_ff @(posedge clk) begin
        if (rst && complete && MemWriteEnM && !bad) begin
            mem_q[word_idx] <= WriteDataM;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ValidW      <= 1'b0;
            RegWriteEnW <= 1'b0;
            RDW         <= 5'd0;
            ResultW     <= 32'd0;
            ErrW        <= 1'b0;
        end else if (!StallM) begin
            ValidW      <= ValidM;
            RegWriteEnW <= ValidM & RegWriteEnM & (RdM != 5'd0);
            RDW         <= RdM;
            ResultW     <= result_d;
            ErrW        <= memop & bad;
        end else begin
            ValidW      <= 1'b0;
            RegWriteEnW <= 1'b0;
            ErrW        <= 1'b0;
        end
    end

endmodule

// File: tb/tb_memwb_stage.sv
// Bench for memwb_stage. An occupancy/memory model is checked every cycle, directed
// vectors add literal expectations, and a second instance covers the zero-latency build.
module tb_memwb_stage;

    localparam int DEPTH = 256;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        ValidM, valid0;
    logic        RegWriteEnM, MemtoRegM, MemReadEnM, MemWriteEnM, JALM;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RdM;

    logic        StallM, ValidW, RegWriteEnW, ErrW;
    logic [4:0]  RDW;
    logic [31:0] ResultW;
    logic        stall0, validw0, rwen0, err0;
    logic [4:0]  rdw0;
    logic [31:0] result0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    memwb_stage #(.DEPTH(DEPTH), .ADDR_W(8), .MEM_LATENCY(LAT)) u_dut (
        .clk(clk), .rst(rst), .ValidM(ValidM), .RegWriteEnM(RegWriteEnM),
        .MemtoRegM(MemtoRegM), .MemReadEnM(MemReadEnM), .MemWriteEnM(MemWriteEnM),
        .JALM(JALM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM),
        .PCPlus4M(PCPlus4M), .StallM(StallM), .ValidW(ValidW), .RegWriteEnW(RegWriteEnW),
        .RDW(RDW), .ResultW(ResultW), .ErrW(ErrW)
    );

    memwb_stage #(.DEPTH(DEPTH), .ADDR_W(8), .MEM_LATENCY(0)) u_dut0 (
        .clk(clk), .rst(rst), .ValidM(valid0), .RegWriteEnM(RegWriteEnM),
        .MemtoRegM(MemtoRegM), .MemReadEnM(MemReadEnM), .MemWriteEnM(MemWriteEnM),
        .JALM(JALM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM),
        .PCPlus4M(PCPlus4M), .StallM(stall0), .ValidW(validw0), .RegWriteEnW(rwen0),
        .RDW(rdw0), .ResultW(result0), .ErrW(err0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a memop occupies M for LAT+1 cycles. It completes on the last cycle and bubbles W before that.
    logic [31:0] m_mem [DEPTH];
    int          m_elapsed = 0;
    bit          live = 0;
    logic        e_validw, e_rwen, e_err, m_memop, m_bad;
    logic [4:0]  e_rdw;
    logic [31:0] e_result, m_rdata;

    always @(posedge clk) begin
        if (!rst) begin
            e_validw = 0; e_rwen = 0; e_err = 0; e_rdw = 0; e_result = 0;
            m_elapsed = 0;
            live = 1;
        end else begin
            m_memop = ValidM & (MemReadEnM | MemWriteEnM);
            if (m_memop && m_elapsed < LAT) begin
                m_elapsed++;
                e_validw = 0; e_rwen = 0; e_err = 0;
            end else begin
                m_bad   = (ALUResultM % 4 != 0) || (ALUResultM >= 4 * DEPTH);
                m_rdata = m_bad ? 32'd0 : m_mem[(ALUResultM / 4) % DEPTH];
                if (m_memop && MemWriteEnM && !m_bad) m_mem[ALUResultM / 4] = WriteDataM;
                e_validw = ValidM;
                e_rwen   = ValidM && RegWriteEnM && RdM != 0;
                e_rdw    = RdM;
                if (JALM) e_result = PCPlus4M;
                else if (MemtoRegM && MemReadEnM && !MemWriteEnM) e_result = m_rdata;
                else e_result = ALUResultM;
                e_err    = m_memop && m_bad;
                m_elapsed = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (live) begin
            check("StallM", 32'(StallM),
                  32'(rst && ValidM && (MemReadEnM || MemWriteEnM) && m_elapsed < LAT));
            check("ValidW", 32'(ValidW), 32'(e_validw));
            check("RegWriteEnW", 32'(RegWriteEnW), 32'(e_rwen));
            check("RDW", 32'(RDW), 32'(e_rdw));
            check("ResultW", ResultW, e_result);
            check("ErrW", 32'(ErrW), 32'(e_err));
        end
    end

    task automatic idle();
        ValidM = 0; valid0 = 0; RegWriteEnM = 0; MemtoRegM = 0; MemReadEnM = 0;
        MemWriteEnM = 0; JALM = 0; ALUResultM = 0; WriteDataM = 0; RdM = 0; PCPlus4M = 0;
    endtask

    task automatic drive(input logic rw, input logic m2r, input logic rd_en, input logic wr_en,
                         input logic jal, input logic [31:0] alu, input logic [31:0] wd,
                         input logic [4:0] rd, input logic [31:0] pc);
        RegWriteEnM = rw; MemtoRegM = m2r; MemReadEnM = rd_en; MemWriteEnM = wr_en;
        JALM = jal; ALUResultM = alu; WriteDataM = wd; RdM = rd; PCPlus4M = pc;
    endtask

    // Issue one instruction to the main instance, hold it while stalled, and return just after it reaches W.
    task automatic send(input logic rw, input logic m2r, input logic rd_en, input logic wr_en,
                        input logic jal, input logic [31:0] alu, input logic [31:0] wd,
                        input logic [4:0] rd, input logic [31:0] pc, output int stalls);
        bit done = 0;
        drive(rw, m2r, rd_en, wr_en, jal, alu, wd, rd, pc);
        ValidM = 1;
        stalls = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (!StallM) done = 1;
            else stalls++;
        end
        if (!done) check("stall_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        int st;
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int st;
        rst = 0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1;
        check("rst_validw", 32'(ValidW), 32'd0);
        check("rst_result", ResultW, 32'd0);

        // ALU op: one cycle, no stall
        send(1, 0, 0, 0, 0, 32'h1234, 0, 5'd5, 0, st);
        check("alu_stalls", 32'(st), 32'd0);
        check("alu_rwen", 32'(RegWriteEnW), 32'd1);
        check("alu_rdw", 32'(RDW), 32'd5);
        check("alu_result", ResultW, 32'h1234);

        // Store then load back
        send(0, 0, 0, 1, 0, 32'h10, 32'hDEADBEEF, 5'd0, 0, st);
        check("st_stalls", 32'(st), 32'd2);
        check("st_validw", 32'(ValidW), 32'd1);
        check("st_err", 32'(ErrW), 32'd0);
        send(1, 1, 1, 0, 0, 32'h10, 0, 5'd7, 0, st);
        check("ld_stalls", 32'(st), 32'd2);
        check("ld_rwen", 32'(RegWriteEnW), 32'd1);
        check("ld_rdw", 32'(RDW), 32'd7);
        check("ld_result", ResultW, 32'hDEADBEEF);

        // Boundary addresses
        send(0, 0, 0, 1, 0, 32'h0, 32'h777, 5'd0, 0, st);
        send(0, 0, 0, 1, 0, 32'h400, 32'hBAD, 5'd0, 0, st);
        check("st_oor_err", 32'(ErrW), 32'd1);
        send(1, 1, 1, 0, 0, 32'h3, 0, 5'd8, 0, st);
        check("ld_mis_result", ResultW, 32'd0);
        check("ld_mis_err", 32'(ErrW), 32'd1);
        send(1, 1, 1, 0, 0, 32'h400, 0, 5'd8, 0, st);
        check("ld_oor_result", ResultW, 32'd0);
        check("ld_oor_err", 32'(ErrW), 32'd1);
        send(1, 1, 1, 0, 0, 32'h0, 0, 5'd9, 0, st);
        check("ld_w0_result", ResultW, 32'h777);
        check("ld_w0_err", 32'(ErrW), 32'd0);

        // JAL, and the x0 destination
        send(1, 0, 0, 0, 1, 32'h55, 0, 5'd1, 32'h84, st);
        check("jal_result", ResultW, 32'h84);
        check("jal_rwen", 32'(RegWriteEnW), 32'd1);
        send(1, 0, 0, 0, 1, 32'h55, 0, 5'd0, 32'h84, st);
        check("jal_x0_rwen", 32'(RegWriteEnW), 32'd0);
        check("jal_x0_result", ResultW, 32'h84);

        // Reset held for 2 cycles while a store is pending
        send(0, 0, 0, 1, 0, 32'h40, 32'h11111111, 5'd0, 0, st);
        drive(0, 0, 0, 1, 0, 32'h40, 32'hAAAA, 5'd0, 0);
        ValidM = 1;
        rst = 0;
        @(negedge clk);
        check("rstp_stall0", 32'(StallM), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("rstp_stall1", 32'(StallM), 32'd0);
        check("rstp_w", {ValidW, RegWriteEnW, ErrW, RDW} | 32'(ResultW != 0), 32'd0);
        @(posedge clk);
        #1;
        idle();
        rst = 1;
        send(1, 1, 1, 0, 0, 32'h40, 0, 5'd4, 0, st);
        check("rstp_mem", ResultW, 32'h11111111);

        // Reset during the 2nd BUSY cycle aborts the store
        send(0, 0, 0, 1, 0, 32'h20, 32'h5, 5'd0, 0, st);
        drive(0, 0, 0, 1, 0, 32'h20, 32'h99, 5'd0, 0);
        ValidM = 1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 0;
        @(negedge clk);
        check("abort_stall_rst", 32'(StallM), 32'd0);
        @(posedge clk);
        #1;
        idle();
        rst = 1;
        @(negedge clk);
        check("abort_stall_idle", 32'(StallM), 32'd0);
        @(posedge clk);
        #1;
        send(1, 1, 1, 0, 0, 32'h20, 0, 5'd6, 0, st);
        check("abort_ld_stalls", 32'(st), 32'd2);
        check("abort_mem", ResultW, 32'h5);

        // Zero-latency instance: back-to-back store and load
        drive(0, 0, 0, 1, 0, 32'h10, 32'hCAFEF00D, 5'd0, 0);
        valid0 = 1;
        @(negedge clk);
        check("l0_st_stall", 32'(stall0), 32'd0);
        @(posedge clk);
        #1;
        check("l0_st_validw", 32'(validw0), 32'd1);
        drive(1, 1, 1, 0, 0, 32'h10, 0, 5'd3, 0);
        @(negedge clk);
        check("l0_ld_stall", 32'(stall0), 32'd0);
        @(posedge clk);
        #1;
        check("l0_ld_rwen", 32'(rwen0), 32'd1);
        check("l0_ld_rdw", 32'(rdw0), 32'd3);
        check("l0_ld_result", result0, 32'hCAFEF00D);
        idle();

        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
